fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the single-issue MIPS core, directly upstream of the decode/control unit. Holds the program counter and runs the iREN/ihit handshake with the instruction cache or RAM arbiter. Presents one registered instruction word per accepted fetch to decode, together with its link address. Handles redirects (jump, branch, JR) from later stages and drains cleanly to a sticky halt when a HALT opcode is fetched.

## Interface
- PC_INIT, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- HALT_OP, 6'b111111, opcode value (instr[31:26]) that triggers halt.

- CLK  in  1  core clock, all state updates on rising edge.
- nRST  in  1  reset; synchronous, active-low.
- iREN  out  1  fetch request to memory.
- iaddr  out  32  fetch address; equals the PC register.
- ihit  in  1  memory returns a word this cycle; meaningful only while iREN=1.
- iload  in  32  fetched word; valid when ihit=1.
- stall  in  1  decode cannot accept the held instruction this cycle.
- redirect  in  1  a later stage demands a PC change this cycle.
- redirect_pc  in  32  new PC; bits [1:0] forced to 0 on load.
- instr  out  32  registered instruction word to decode.
- instr_valid  out  1  instr holds a live instruction.
- npc  out  32  address of instr + 4, used for the JAL link and branch base.
- halt  out  1  sticky; processor halted.

## Operation
- FSM states: RUN, DRAIN, HALTED.
- iREN = (state==RUN) && !(instr_valid && stall).
- accept = iREN && ihit && !redirect.
- consume = instr_valid && !stall.
- RUN:
  - On accept: instr<=iload, npc<=PC+4, instr_valid<=1, PC<=PC+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
  - If the accepted word has iload[31:26]==HALT_OP, go to DRAIN.
  - Without accept: consume clears instr_valid; otherwise instr_valid holds.
- DRAIN: no fetch; HALT instruction waits in instr. On consume: instr_valid<=0 and go to HALTED.
- HALTED: halt=1 and iREN=0. All inputs, including redirect, are ignored. Only reset exits this state.
- redirect in RUN or DRAIN has highest priority after reset:
  - PC<={redirect_pc[31:2],2'b00} and instr_valid<=0 (wrong-path instruction flushed regardless of stall).
  - Any simultaneous ihit is discarded.
  - State goes to RUN. A HALT in DRAIN was on the wrong path and is cancelled.
- instr and npc change only on accept. They hold their value while instr_valid=0.
- ihit while iREN=0 is ignored.

## Timing
- Reset values (nRST low at a rising edge): PC=PC_INIT, state=RUN, instr=0, npc=0, instr_valid=0, halt=0. This gives iaddr=PC_INIT and iREN=1 in the first cycle after reset.
- Reset mid-fetch aborts the fetch. An ihit in the reset cycle is discarded.
- Fetch latency: ihit in cycle N produces instr_valid=1 in cycle N+1, and iaddr moves to PC+4 in cycle N+1.
- Back-to-back: with ihit=1 every cycle and stall=0, one instruction is delivered per cycle.
- Decode takes instr on the edge where consume=1. If accept occurs on the same edge, instr is replaced with no bubble.
- Stall backpressure: iREN drops combinationally when instr_valid && stall, so the held instr is never overwritten.
- Redirect latency: redirect in cycle N gives iaddr=redirect_pc in cycle N+1 and instr_valid=0 in cycle N+1.
- halt rises the cycle after the HALT instruction is consumed.
- Memory wait states: iaddr is held stable and iREN stays high until ihit arrives.

## Test plan
- Reset with PC_INIT=0:
  - After reset: iaddr=0, iREN=1, instr_valid=0, halt=0.
  - ihit=1 with iload=32'h3421_0005 → next cycle instr=32'h3421_0005, npc=4, iaddr=4.
- Wait states: hold ihit=0 for 3 cycles at iaddr=8 → iaddr stays 8 and iREN stays 1. ihit in cycle 4 → instr_valid=1 next cycle.
- Stall: instr_valid=1 with stall=1 for 2 cycles → iREN=0 and instr unchanged even if ihit pulses. Releasing stall → iREN=1 and the next word is accepted.
- Redirect with ihit in the same cycle: redirect_pc=32'h0000_0103 → iaddr=32'h0000_0100, instr_valid=0, and the hit word is discarded.
- Halt:
  - Fetch 32'hFFFF_FFFF with stall=1 for 2 cycles → state DRAIN, iREN=0, halt=0.
  - Release stall → halt=1 one cycle after consume; halt stays 1 under later redirect and ihit until nRST is low.
- Redirect in DRAIN cancels the halt: redirect_pc=32'h40 → halt stays 0, iREN=1, iaddr=32'h40. PC wrap check: from 32'hFFFF_FFFC, an accepted fetch gives iaddr=0 and npc=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage holding the PC, running the iREN/ihit handshake
// and presenting one registered instruction to decode, with redirect and sticky halt.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    output logic        o_iren,
    output logic [31:0] o_iaddr,
    input  logic        i_ihit,
    input  logic [31:0] i_iload,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic [31:0] o_npc,
    output logic        o_halt
);
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_npc;
    logic        r_valid;
    logic        w_accept;
    logic        w_consume;

    assign o_iren        = (r_state == RUN) && !(r_valid && i_stall);
    assign w_accept      = o_iren && i_ihit && !i_redirect;
    assign w_consume     = r_valid && !i_stall;
    assign o_iaddr       = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_valid;
    assign o_npc         = r_npc;
    assign o_halt        = r_state == HALTED;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state <= RUN;
            r_pc    <= PC_INIT;
            r_instr <= '0;
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else if (r_state != HALTED) begin
            // A redirect flushes the held word even under stall and cancels a pending halt.
            if (i_redirect) begin
                r_pc    <= i_redirect_pc & ~32'h3;
                r_valid <= 1'b0;
                r_state <= RUN;
            end else if (w_accept) begin
                r_instr <= i_iload;
                r_npc   <= r_pc + 32'd4;
                r_pc    <= r_pc + 32'd4;
                r_valid <= 1'b1;
                if (i_iload[31:26] == HALT_OP)
                    r_state <= DRAIN;
            end else if (w_consume) begin
                r_valid <= 1'b0;
                if (r_state == DRAIN)
                    r_state <= HALTED;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan sequence followed by random traffic, checked
// against a behavioural PC/queue model with a scoreboard monitor on consumed instructions.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        ihit = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] iload = '0;
    logic [31:0] rpc = '0;
    logic        o_iren;
    logic [31:0] o_iaddr;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic [31:0] o_npc;
    logic        o_halt;

    int n_pass = 0;
    int n_total = 0;
    bit started = 0;

    logic [31:0] m_pc = '0;
    bit          m_valid = 0;
    bit          m_drain = 0;
    bit          m_halt = 0;
    logic [63:0] sb[$];

    fetch_unit dut (
        .i_clk(clk), .i_nrst(nrst), .o_iren(o_iren), .o_iaddr(o_iaddr),
        .i_ihit(ihit), .i_iload(iload), .i_stall(stall), .i_redirect(redirect),
        .i_redirect_pc(rpc), .o_instr(o_instr), .o_instr_valid(o_instr_valid),
        .o_npc(o_npc), .o_halt(o_halt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: a PC, one holding slot and a halt flag, updated from the inputs seen at each edge.
    always @(posedge clk) begin
        if (!nrst) begin
            m_pc = 32'h0; m_valid = 0; m_drain = 0; m_halt = 0;
            sb.delete();
            started = 1;
        end else if (started && !m_halt) begin
            if (redirect) begin
                m_pc = {rpc[31:2], 2'b00}; m_valid = 0; m_drain = 0;
                sb.delete();
            end else if (!m_drain && !(m_valid && stall) && ihit) begin
                sb.push_back({iload, m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
                m_valid = 1;
                m_drain = iload[31:26] == 6'h3f;
            end else if (m_valid && !stall) begin
                m_valid = 0;
                if (m_drain) begin m_drain = 0; m_halt = 1; end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("iaddr", o_iaddr, m_pc);
            check("iren", {31'b0, o_iren}, {31'b0, !m_drain && !m_halt && !(m_valid && stall)});
            check("halt", {31'b0, o_halt}, {31'b0, m_halt});
            check("instr_valid", {31'b0, o_instr_valid}, {31'b0, m_valid});
            if (o_instr_valid && !stall) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL scoreboard: instr %h presented with nothing expected", o_instr);
                end else begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    check("instr", o_instr, e[63:32]);
                    check("npc", o_npc, e[31:0]);
                end
            end
        end
    end

    task automatic step(input bit h, input logic [31:0] w, input bit s, input bit r, input logic [31:0] p);
        ihit = h; iload = w; stall = s; redirect = r; rpc = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hc;
        nrst = 0;
        step(1, 32'h1111_1111, 0, 0, 0);
        step(1, 32'h1111_1111, 0, 0, 0);
        nrst = 1;
        check("rst_iaddr", o_iaddr, 32'h0);
        check("rst_iren", {31'b0, o_iren}, 32'h1);
        check("rst_valid", {31'b0, o_instr_valid}, 32'h0);
        check("rst_halt", {31'b0, o_halt}, 32'h0);
        step(1, 32'h3421_0005, 0, 0, 0);
        check("first_instr", o_instr, 32'h3421_0005);
        check("first_npc", o_npc, 32'h4);
        check("first_iaddr", o_iaddr, 32'h4);
        step(1, 32'h2000_0001, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 0, 0, 0);
            check("wait_iaddr", o_iaddr, 32'h8);
            check("wait_iren", {31'b0, o_iren}, 32'h1);
        end
        step(1, 32'h2000_0002, 0, 0, 0);
        check("wait_valid", {31'b0, o_instr_valid}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            step(1, 32'hDEAD_BEEF, 1, 0, 0);
            check("stall_iren", {31'b0, o_iren}, 32'h0);
            check("stall_instr", o_instr, 32'h2000_0002);
        end
        step(1, 32'h2000_0003, 0, 0, 0);
        check("unstall_instr", o_instr, 32'h2000_0003);
        step(1, 32'hBAD0_0BAD, 0, 1, 32'h0000_0103);
        check("redir_iaddr", o_iaddr, 32'h0000_0100);
        check("redir_valid", {31'b0, o_instr_valid}, 32'h0);
        step(1, 32'hFFFF_FFFF, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 32'h0, 1, 0, 0);
            check("drain_iren", {31'b0, o_iren}, 32'h0);
            check("drain_halt", {31'b0, o_halt}, 32'h0);
        end
        step(0, 32'h0, 0, 0, 0);
        check("halt_rise", {31'b0, o_halt}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h1234_5678, 0, 1, 32'h0000_0200);
            check("halt_sticky", {31'b0, o_halt}, 32'h1);
        end
        nrst = 0;
        step(0, 32'h0, 0, 0, 0);
        nrst = 1;
        check("halt_reset", {31'b0, o_halt}, 32'h0);
        step(1, 32'hFC00_0000, 0, 0, 0);
        step(0, 32'h0, 1, 1, 32'h0000_0040);
        check("cancel_halt", {31'b0, o_halt}, 32'h0);
        check("cancel_iren", {31'b0, o_iren}, 32'h1);
        check("cancel_iaddr", o_iaddr, 32'h0000_0040);
        step(0, 32'h0, 0, 1, 32'hFFFF_FFFF);
        check("wrap_pre", o_iaddr, 32'hFFFF_FFFC);
        step(1, 32'h0000_0001, 0, 0, 0);
        check("wrap_iaddr", o_iaddr, 32'h0);
        check("wrap_npc", o_npc, 32'h0);
        hc = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 7) != 0 && w[31:26] == 6'h3f) w[26] = 1'b0;
            hc = m_halt ? hc + 1 : 0;
            nrst = !(hc > 8 || $urandom_range(0, 299) == 0);
            step($urandom_range(0, 1) == 1, w, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 19) == 0, $urandom);
        end
        nrst = 1;
        step(0, 32'h0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
